// File: rtl/mano_ctrl_pkg.sv
// Shared constants for the basic-computer control unit: T-state indices,
// opcode encodings and instruction-register field positions.
package mano_ctrl_pkg;

    // Sequence counter and timing bus geometry
    localparam int unsigned SC_WIDTH  = 3;
    localparam int unsigned T_WIDTH   = 1 << SC_WIDTH;

    // Instruction register fields
    localparam int unsigned IR_WIDTH  = 16;
    localparam int unsigned OPC_LSB   = 12;
    localparam int unsigned OPC_WIDTH = 3;
    localparam int unsigned D_WIDTH   = 1 << OPC_WIDTH;

    // T-state indices
    localparam logic [SC_WIDTH-1:0] T0 = 3'd0;
    localparam logic [SC_WIDTH-1:0] T1 = 3'd1;
    localparam logic [SC_WIDTH-1:0] T2 = 3'd2;
    localparam logic [SC_WIDTH-1:0] T3 = 3'd3;
    localparam logic [SC_WIDTH-1:0] T4 = 3'd4;
    localparam logic [SC_WIDTH-1:0] T5 = 3'd5;
    localparam logic [SC_WIDTH-1:0] T6 = 3'd6;
    localparam logic [SC_WIDTH-1:0] T7 = 3'd7;

    // Timing state in which D and I are captured
    localparam int unsigned DECODE_T  = 2;

    // Opcode field encodings; OP_RIO covers the register-reference/IO group
    typedef enum logic [OPC_WIDTH-1:0] {
        OP_AND = 3'd0,
        OP_ADD = 3'd1,
        OP_LDA = 3'd2,
        OP_STA = 3'd3,
        OP_BUN = 3'd4,
        OP_BSA = 3'd5,
        OP_ISZ = 3'd6,
        OP_RIO = 3'd7
    } opcode_e;

endpackage

// File: rtl/decoder_3to8.sv
// 3-bit binary to 8-bit one-hot decoder with an enable; all zero when disabled.
module decoder_3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    // One-hot decode of sel, gated by en
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_timing_decode.sv
// Sequence counter, start/stop flip-flop, opcode decode latch and indirect bit
// for the basic-computer control unit. Produces the T and D one-hot buses.
module seq_timing_decode #(
    parameter int unsigned SC_WIDTH = mano_ctrl_pkg::SC_WIDTH,
    parameter int unsigned IR_WIDTH = mano_ctrl_pkg::IR_WIDTH,
    parameter int unsigned OPC_LSB  = mano_ctrl_pkg::OPC_LSB,
    parameter int unsigned DECODE_T = mano_ctrl_pkg::DECODE_T
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IR_WIDTH-1:0]      ir,
    input  logic                     start,
    input  logic                     halt,
    input  logic                     sc_clr,
    output logic [(1<<SC_WIDTH)-1:0] T,
    output logic [7:0]               D,
    output logic                     I,
    output logic [SC_WIDTH-1:0]      sc,
    output logic                     running,
    output logic                     timing_err
);

    import mano_ctrl_pkg::*;

    localparam int unsigned TW = 1 << SC_WIDTH;

    logic [SC_WIDTH-1:0]  sc_q, sc_d;
    logic                 running_q, running_d;
    logic                 err_q, err_d;
    logic [D_WIDTH-1:0]   d_q, d_d;
    logic                 i_q, i_d;
    logic                 latch_en;
    logic [D_WIDTH-1:0]   opc_onehot;
    logic [OPC_WIDTH-1:0] opc;

    assign opc      = ir[OPC_LSB +: OPC_WIDTH];
    assign latch_en = running_q && (sc_q == SC_WIDTH'(DECODE_T));

    // Opcode decode feeding the D latch; always enabled, capture is gated below
    decoder_3to8 u_opc_dec (
        .en  (1'b1),
        .sel (opc),
        .y   (opc_onehot)
    );

    // Timing bus: one-hot of sc while running, zero when stopped
    if (SC_WIDTH == 3) begin : g_t_dec
        decoder_3to8 u_t_dec (
            .en  (running_q),
            .sel (sc_q),
            .y   (T)
        );
    end else begin : g_t_shift
        assign T = running_q ? (TW'(1) << sc_q) : '0;
    end

    // Next-state for S, SC and the sticky wrap flag; halt overrides everything
    always_comb begin
        running_d = running_q;
        sc_d      = sc_q;
        err_d     = err_q;
        if (halt) begin
            running_d = 1'b0;
            sc_d      = '0;
        end else if (!running_q) begin
            // SC stays at 0 while stopped; first T0 appears the cycle after start
            running_d = start;
            sc_d      = '0;
        end else if (sc_clr) begin
            sc_d = '0;
        end else begin
            sc_d = sc_q + 1'b1;
            if (sc_q == '1) begin
                err_d = 1'b1;
            end
        end
    end

    // D/I capture at the decode T-state, independent of halt/sc_clr that cycle
    always_comb begin
        d_d = d_q;
        i_d = i_q;
        if (latch_en) begin
            d_d = opc_onehot;
            i_d = ir[IR_WIDTH-1];
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q      <= '0;
            running_q <= 1'b0;
            err_q     <= 1'b0;
            d_q       <= '0;
            i_q       <= 1'b0;
        end else begin
            sc_q      <= sc_d;
            running_q <= running_d;
            err_q     <= err_d;
            d_q       <= d_d;
            i_q       <= i_d;
        end
    end

    assign D          = d_q;
    assign I          = i_q;
    assign sc         = sc_q;
    assign running    = running_q;
    assign timing_err = err_q;

endmodule
